axil_slave_regfile: RTL and testbench
=====================================

# axil_slave_regfile

AXI-Lite responder endpoint that terminates one slave port of the AXI-Lite interconnect and exposes a bank of word-wide registers. Read-write registers drive fabric logic. Read-only registers sample fabric status inputs. Write address/data and read address are decoded against a base offset; out-of-range and illegal accesses complete with error responses so the interconnect never stalls.

## Interface
- NUMBER_REG, 16, number of registers (≥1).
- AXI_DATA_WIDTH, 32, register and bus data width (32 or 64).
- AXI_ADDR_WIDTH, 32, address width.
- AXI_ADDR_OFFSET, 32'h0000_0000, byte base address of register 0. Register stride is AXI_DATA_WIDTH/8 bytes.
- RO_MASK, '0 (NUMBER_REG bits), bit i set: register i is read-only (reads return reg_in[i]).
- aclk  in  1  clock; single clock domain.
- aresetn  in  1  reset, asynchronous, active-low.
- s_axil_awaddr  in  AXI_ADDR_WIDTH  write address.
- s_axil_awvalid / s_axil_awready  in/out  1  write address handshake.
- s_axil_wdata  in  AXI_DATA_WIDTH  write data.
- s_axil_wstrb  in  AXI_DATA_WIDTH/8  byte enables.
- s_axil_wvalid / s_axil_wready  in/out  1  write data handshake.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid / s_axil_bready  out/in  1  write response handshake.
- s_axil_araddr  in  AXI_ADDR_WIDTH  read address.
- s_axil_arvalid / s_axil_arready  in/out  1  read address handshake.
- s_axil_rdata  out  AXI_DATA_WIDTH  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid / s_axil_rready  out/in  1  read data handshake.
- reg_out  out  AXI_DATA_WIDTH [NUMBER_REG]  current register contents (read-only slots drive 0).
- reg_in  in  AXI_DATA_WIDTH [NUMBER_REG]  status inputs for read-only slots; ignored for read-write slots.
- reg_wr_pulse  out  NUMBER_REG  one-cycle strobe for each successful write to a register.

## Operation
- Decode:
  - idx = (addr − AXI_ADDR_OFFSET) >> log2(AXI_DATA_WIDTH/8). Low address bits are ignored.
  - addr < AXI_ADDR_OFFSET or idx ≥ NUMBER_REG: DECERR (2'b11).
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: awready = !aw_held and wready = !w_held. AW and W are accepted independently, in either order or the same cycle, and latched into holding registers.
  - W_IDLE with aw_held & w_held:
    - Decode.
    - On a read-write hit, update the bytes selected by wstrb, pulse reg_wr_pulse[idx], and set bresp OKAY.
    - On a read-only hit, leave contents unchanged and set bresp SLVERR (2'b10).
    - On a miss, set bresp DECERR.
    - Set bvalid=1 and go to W_RESP.
  - W_RESP: awready=wready=0. On bvalid&bready, clear bvalid and both holds, then go to W_IDLE.
  - wstrb=0 to a read-write register: OKAY, no data change, pulse still asserted.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: arready=1. On handshake, decode and load rdata/rresp registers:
    - read-write: register value, OKAY.
    - read-only: reg_in[idx] sampled at the handshake edge, OKAY.
    - miss: rdata=0, DECERR.
  - After loading, set rvalid=1 and go to R_DATA.
  - R_DATA: arready=0. rdata/rresp are held stable. On rvalid&rready, clear rvalid and go to R_IDLE.
- The read and write paths are fully independent. A read and a write to the same register that both resolve on one edge: the read returns the pre-write value.

## Timing
- Reset values:
  - all registers 0; reg_out=0.
  - awready=1, wready=1, arready=1.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, reg_wr_pulse=0.
  - Both FSMs idle; holds cleared.
- Reset mid-transaction aborts immediately: pending write is discarded, bvalid/rvalid drop asynchronously.
- Write latency:
  - AW and W handshaked in cycle 0 give reg_out update, reg_wr_pulse and bvalid in cycle 2.
  - A late channel adds its delay.
  - Minimum write-to-write spacing is 3 cycles with bready held high.
- Read latency: AR handshake in cycle 0 gives rvalid in cycle 1. Minimum spacing is 2 cycles with rready held high.
- bvalid/rvalid stay asserted, with payload stable, until accepted (backpressure of any length).
- reg_wr_pulse is exactly one cycle, coincident with the first bvalid cycle.

## Test plan
- Reset, then AW=0x8/W=0xDEADBEEF/wstrb=4'hF in the same cycle, bready=1:
  - bvalid in cycle 2, bresp=0, reg_out[2]=0xDEADBEEF, reg_wr_pulse=0x0004 for one cycle.
  - AR=0x8 then returns rvalid after 1 cycle, rdata=0xDEADBEEF, rresp=0.
- W presented 3 cycles before AW, wstrb=4'b0101, data 0x11223344 onto 0xFFFFFFFF in reg 1:
  - reg_out[1]=0xFF22FF44.
  - wready=0 after W accepted until the response completes.
- RO_MASK bit 3 set, reg_in[3]=0xCAFE0001:
  - write to 0xC gives bresp=2'b10 and no pulse.
  - read of 0xC gives rdata=0xCAFE0001, OKAY.
- Address 0x40 with NUMBER_REG=16:
  - write gives bresp=2'b11 with all registers unchanged.
  - read gives rdata=0, rresp=2'b11.
- bready/rready held low 10 cycles: bvalid/rvalid and payloads stable. awready/wready/arready stay 0 until accepted, then return to 1 the next cycle.
- aresetn pulled low while bvalid pending:
  - outputs drop to reset values immediately.
  - after release, a new write completes normally and no stale response appears.

Source files
------------

// File: rtl/axil_slave_regfile.sv
// axil_slave_regfile
//
// AXI-Lite slave that exposes NUMBER_REG word-wide registers. Read-write
// slots are stored locally and driven on reg_out; read-only slots (RO_MASK)
// return reg_in on reads and reject writes with SLVERR. Accesses outside the
// register window complete with DECERR so the interconnect never stalls.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*     write address, write data, write response channels
//   s_axil_ar*/r*        read address, read data channels
//   reg_out[NUMBER_REG]  register contents (read-only slots drive 0)
//   reg_in[NUMBER_REG]   status inputs, only used for read-only slots
//   reg_wr_pulse         one-cycle strobe per successful register write
//
// Write FSM
//   state  | meaning
//   W_IDLE | collecting AW and W into holding registers; commits once both held
//   W_RESP | bvalid asserted, waiting for bready
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, decode and load rdata/rresp on AR handshake
//   R_DATA | rvalid asserted, payload held until rready

module axil_slave_regfile #(
    parameter int                          NUMBER_REG      = 16,
    parameter int                          AXI_DATA_WIDTH  = 32,
    parameter int                          AXI_ADDR_WIDTH  = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0]   AXI_ADDR_OFFSET = '0,
    parameter logic [NUMBER_REG-1:0]       RO_MASK         = '0
) (
    input  logic                          aclk,
    input  logic                          aresetn,

    input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
    input  logic                          s_axil_awvalid,
    output logic                          s_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
    input  logic                          s_axil_wvalid,
    output logic                          s_axil_wready,
    output logic [1:0]                    s_axil_bresp,
    output logic                          s_axil_bvalid,
    input  logic                          s_axil_bready,

    input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_araddr,
    input  logic                          s_axil_arvalid,
    output logic                          s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0]     s_axil_rdata,
    output logic [1:0]                    s_axil_rresp,
    output logic                          s_axil_rvalid,
    input  logic                          s_axil_rready,

    output logic [AXI_DATA_WIDTH-1:0]     reg_out [NUMBER_REG],
    input  logic [AXI_DATA_WIDTH-1:0]     reg_in  [NUMBER_REG],
    output logic [NUMBER_REG-1:0]         reg_wr_pulse
);

    localparam int STRB_W   = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Word index relative to the base; only meaningful when dec_hit is true.
    function automatic logic [AXI_ADDR_WIDTH-1:0] dec_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return (addr - AXI_ADDR_OFFSET) >> ADDR_LSB;
    endfunction

    function automatic logic dec_hit(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return (addr >= AXI_ADDR_OFFSET) &&
               (dec_idx(addr) < AXI_ADDR_WIDTH'(NUMBER_REG));
    endfunction

    // Write path state
    w_state_t                    w_state_q, w_state_d;
    logic                        aw_held_q, aw_held_d;
    logic                        w_held_q,  w_held_d;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr_q,  awaddr_d;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q,   wdata_d;
    logic [STRB_W-1:0]           wstrb_q,   wstrb_d;
    logic                        bvalid_q,  bvalid_d;
    logic [1:0]                  bresp_q,   bresp_d;
    logic [NUMBER_REG-1:0]       wr_pulse_q, wr_pulse_d;
    logic [AXI_DATA_WIDTH-1:0]   regs_q [NUMBER_REG];
    logic [AXI_DATA_WIDTH-1:0]   regs_d [NUMBER_REG];
    logic [AXI_ADDR_WIDTH-1:0]   wr_idx;
    logic                        wr_hit;

    // Read path state
    r_state_t                    r_state_q, r_state_d;
    logic                        rvalid_q,  rvalid_d;
    logic [1:0]                  rresp_q,   rresp_d;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q,   rdata_d;
    logic [AXI_ADDR_WIDTH-1:0]   rd_idx;
    logic                        rd_hit;

    always_comb begin
        w_state_d      = w_state_q;
        aw_held_d      = aw_held_q;
        w_held_d       = w_held_q;
        awaddr_d       = awaddr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        bvalid_d       = bvalid_q;
        bresp_d        = bresp_q;
        wr_pulse_d     = '0;
        regs_d         = regs_q;
        s_axil_awready = 1'b0;
        s_axil_wready  = 1'b0;
        wr_idx         = dec_idx(awaddr_q);
        wr_hit         = dec_hit(awaddr_q);

        case (w_state_q)
            W_IDLE: begin
                s_axil_awready = !aw_held_q;
                s_axil_wready  = !w_held_q;
                if (s_axil_awvalid && !aw_held_q) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_axil_awaddr;
                end
                if (s_axil_wvalid && !w_held_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axil_wdata;
                    wstrb_d  = s_axil_wstrb;
                end
                // Commit uses the held copies, so a channel arriving this
                // cycle is acted on one cycle later.
                if (aw_held_q && w_held_q) begin
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                    bresp_d   = wr_hit ? RESP_OKAY : RESP_DECERR;
                    for (int i = 0; i < NUMBER_REG; i++) begin
                        if (wr_hit && (wr_idx == AXI_ADDR_WIDTH'(i))) begin
                            if (RO_MASK[i]) begin
                                bresp_d = RESP_SLVERR;
                            end else begin
                                wr_pulse_d[i] = 1'b1;
                                for (int b = 0; b < STRB_W; b++) begin
                                    if (wstrb_q[b]) begin
                                        regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                                    end
                                end
                            end
                        end
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && s_axil_bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d      = r_state_q;
        rvalid_d       = rvalid_q;
        rresp_d        = rresp_q;
        rdata_d        = rdata_q;
        s_axil_arready = 1'b0;
        rd_idx         = dec_idx(s_axil_araddr);
        rd_hit         = dec_hit(s_axil_araddr);

        case (r_state_q)
            R_IDLE: begin
                s_axil_arready = 1'b1;
                if (s_axil_arvalid) begin
                    rvalid_d  = 1'b1;
                    r_state_d = R_DATA;
                    rresp_d   = rd_hit ? RESP_OKAY : RESP_DECERR;
                    rdata_d   = '0;
                    // regs_q (not regs_d) so a same-edge write is not visible.
                    for (int i = 0; i < NUMBER_REG; i++) begin
                        if (rd_hit && (rd_idx == AXI_ADDR_WIDTH'(i))) begin
                            rdata_d = RO_MASK[i] ? reg_in[i] : regs_q[i];
                        end
                    end
                end
            end
            R_DATA: begin
                if (s_axil_rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q  <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUMBER_REG; i++) begin
                regs_q[i] <= '0;
            end
            r_state_q  <= R_IDLE;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            w_state_q  <= w_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            for (int i = 0; i < NUMBER_REG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            r_state_q  <= r_state_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUMBER_REG; i++) begin
            reg_out[i] = RO_MASK[i] ? '0 : regs_q[i];
        end
    end

    assign s_axil_bvalid = bvalid_q;
    assign s_axil_bresp  = bresp_q;
    assign s_axil_rvalid = rvalid_q;
    assign s_axil_rresp  = rresp_q;
    assign s_axil_rdata  = rdata_q;
    assign reg_wr_pulse  = wr_pulse_q;

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Testbench for axil_slave_regfile: directed vector table, hand-written
// multi-cycle sequences and a randomized phase against a word-array model.

module tb_axil_slave_regfile;

    localparam logic [15:0] RO  = 16'h0008;
    localparam logic [31:0] OFF = 32'h0;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_axil_awaddr;
    logic        s_axil_awvalid, s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid, s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid, s_axil_bready;
    logic [31:0] s_axil_araddr;
    logic        s_axil_arvalid, s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid, s_axil_rready;
    logic [31:0] reg_out [16];
    logic [31:0] reg_in  [16];
    logic [15:0] reg_wr_pulse;

    axil_slave_regfile #(
        .NUMBER_REG(16), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32),
        .AXI_ADDR_OFFSET(OFF), .RO_MASK(RO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .reg_out(reg_out), .reg_in(reg_in), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_idx(input logic [31:0] a);
        if (a < OFF) return -1;
        if ((a - OFF) / 4 >= 16) return -1;
        return int'((a - OFF) / 4);
    endfunction

    function automatic logic [1:0] m_wresp(input logic [31:0] a);
        int idx = m_idx(a);
        if (idx < 0) return 2'b11;
        if (RO[idx]) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [15:0] m_pulse(input logic [31:0] a);
        if (m_wresp(a) != 2'b00) return 16'h0;
        return 16'(1) << m_idx(a);
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx = m_idx(a);
        if (m_wresp(a) == 2'b00)
            for (int b = 0; b < 4; b++)
                if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic m_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int idx = m_idx(a);
        if (idx < 0) begin d = 32'h0; r = 2'b11; end
        else begin d = RO[idx] ? reg_in[idx] : model[idx]; r = 2'b00; end
    endtask

    function automatic bit regs_match();
        for (int i = 0; i < 16; i++)
            if (reg_out[i] !== (RO[i] ? 32'h0 : model[i])) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- bus tasks (called #1 after a posedge) ----------------
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output logic [15:0] pulse,
                            output logic [15:0] pulse_after, output int lat);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0;
        resp = 2'bxx; pulse = 'x; pulse_after = 'x; lat = -1;
        s_axil_bready = 1'b1;
        s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
        while (!(aw_done && w_done) && cyc < 50) begin
            s_axil_awvalid = !aw_done && (cyc >= aw_dly);
            s_axil_wvalid  = !w_done  && (cyc >= w_dly);
            aw_hs = s_axil_awvalid && s_axil_awready;
            w_hs  = s_axil_wvalid  && s_axil_wready;
            @(posedge aclk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done  = 1;
            cyc++;
        end
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        if (!(aw_done && w_done)) begin
            check("write_accept_timeout", 0, 1);
            return;
        end
        cyc = 0;
        while (!s_axil_bvalid && cyc < 20) begin @(posedge aclk); #1; cyc++; end
        if (!s_axil_bvalid) begin
            check("write_resp_timeout", 0, 1);
            return;
        end
        lat = cyc; resp = s_axil_bresp; pulse = reg_wr_pulse;
        @(posedge aclk); #1;
        pulse_after = reg_wr_pulse;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] r, output int lat);
        bit hs;
        int cyc;
        hs = 0; cyc = 0; d = 'x; r = 2'bxx; lat = -1;
        s_axil_araddr = a; s_axil_rready = 1'b1; s_axil_arvalid = 1'b1;
        while (!hs && cyc < 50) begin
            hs = s_axil_arready;
            @(posedge aclk); #1;
            cyc++;
        end
        s_axil_arvalid = 1'b0;
        if (!hs) begin
            check("read_accept_timeout", 0, 1);
            return;
        end
        cyc = 0;
        while (!s_axil_rvalid && cyc < 20) begin @(posedge aclk); #1; cyc++; end
        if (!s_axil_rvalid) begin
            check("read_resp_timeout", 0, 1);
            return;
        end
        lat = cyc; d = s_axil_rdata; r = s_axil_rresp;
        @(posedge aclk); #1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [15:0] pulse;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r, er;
        logic [15:0] p, p2;
        logic [31:0] rd, ed, a, d;
        logic [3:0]  s;
        int          lat;
        bit          ok;

        vecs[0]  = '{1'b1, 32'h08,       32'hDEADBEEF, 4'hF, 2'b00, 32'h0,        16'h0004};
        vecs[1]  = '{1'b0, 32'h08,       32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 16'h0000};
        vecs[2]  = '{1'b1, 32'h04,       32'hFFFFFFFF, 4'hF, 2'b00, 32'h0,        16'h0002};
        vecs[3]  = '{1'b1, 32'h0C,       32'h12345678, 4'hF, 2'b10, 32'h0,        16'h0000};
        vecs[4]  = '{1'b0, 32'h0C,       32'h0,        4'h0, 2'b00, 32'hCAFE0001, 16'h0000};
        vecs[5]  = '{1'b1, 32'h40,       32'hAAAAAAAA, 4'hF, 2'b11, 32'h0,        16'h0000};
        vecs[6]  = '{1'b0, 32'h40,       32'h0,        4'h0, 2'b11, 32'h0,        16'h0000};
        vecs[7]  = '{1'b1, 32'h0A,       32'h00000000, 4'h0, 2'b00, 32'h0,        16'h0004};
        vecs[8]  = '{1'b0, 32'h0B,       32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 16'h0000};
        vecs[9]  = '{1'b1, 32'h3C,       32'h1234A5A5, 4'h3, 2'b00, 32'h0,        16'h8000};
        vecs[10] = '{1'b0, 32'h3C,       32'h0,        4'h0, 2'b00, 32'h0000A5A5, 16'h0000};
        vecs[11] = '{1'b0, 32'h04,       32'h0,        4'h0, 2'b00, 32'hFFFFFFFF, 16'h0000};
        vecs[12] = '{1'b1, 32'hFFFFFFFC, 32'h00000001, 4'hF, 2'b11, 32'h0,        16'h0000};
        vecs[13] = '{1'b0, 32'h1000,     32'h0,        4'h0, 2'b11, 32'h0,        16'h0000};

        s_axil_awaddr = 0; s_axil_awvalid = 0; s_axil_wdata = 0; s_axil_wstrb = 0;
        s_axil_wvalid = 0; s_axil_bready = 0; s_axil_araddr = 0; s_axil_arvalid = 0;
        s_axil_rready = 0;
        for (int i = 0; i < 16; i++) begin
            reg_in[i] = 32'h1000_0000 + i;
            model[i]  = 32'h0;
        end
        reg_in[3] = 32'hCAFE0001;

        aresetn = 1'b1;
        #1 aresetn = 1'b0;
        #1;
        check("rst_awready", s_axil_awready, 1);
        check("rst_wready",  s_axil_wready,  1);
        check("rst_arready", s_axil_arready, 1);
        check("rst_bvalid",  s_axil_bvalid,  0);
        check("rst_rvalid",  s_axil_rvalid,  0);
        check("rst_bresp",   s_axil_bresp,   0);
        check("rst_rresp",   s_axil_rresp,   0);
        check("rst_rdata",   s_axil_rdata,   0);
        check("rst_pulse",   reg_wr_pulse,   0);
        check("rst_regs",    regs_match(),   1);
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;

        // Directed table
        for (int k = 0; k < NV; k++) begin
            if (vecs[k].wr) begin
                do_write(vecs[k].addr, vecs[k].data, vecs[k].strb, 0, 0, r, p, p2, lat);
                m_write(vecs[k].addr, vecs[k].data, vecs[k].strb);
                check($sformatf("vec%0d_bresp", k), r, vecs[k].resp);
                check($sformatf("vec%0d_pulse", k), p, vecs[k].pulse);
                check($sformatf("vec%0d_pulse_len", k), p2, 0);
                check($sformatf("vec%0d_blat", k), lat, 1);
                check($sformatf("vec%0d_regs", k), regs_match(), 1);
            end else begin
                do_read(vecs[k].addr, rd, r, lat);
                check($sformatf("vec%0d_rdata", k), rd, vecs[k].rdata);
                check($sformatf("vec%0d_rresp", k), r, vecs[k].resp);
                check($sformatf("vec%0d_rlat", k), lat, 0);
            end
        end
        check("reg2_value", reg_out[2], 32'hDEADBEEF);

        // W arrives 3 cycles before AW, partial strobe onto reg 1
        s_axil_bready = 1'b1;
        s_axil_wdata = 32'h11223344; s_axil_wstrb = 4'b0101; s_axil_wvalid = 1'b1;
        @(posedge aclk); #1;
        s_axil_wvalid = 1'b0;
        ok = 1;
        repeat (3) begin
            ok = ok && !s_axil_wready && s_axil_awready;
            @(posedge aclk); #1;
        end
        s_axil_awaddr = 32'h4; s_axil_awvalid = 1'b1;
        ok = ok && !s_axil_wready;
        @(posedge aclk); #1;
        s_axil_awvalid = 1'b0;
        ok = ok && !s_axil_wready && !s_axil_awready && !s_axil_bvalid;
        @(posedge aclk); #1;
        ok = ok && !s_axil_wready;
        check("late_aw_bvalid", s_axil_bvalid, 1);
        check("late_aw_bresp",  s_axil_bresp,  0);
        check("late_aw_pulse",  reg_wr_pulse,  16'h0002);
        check("late_aw_reg1",   reg_out[1],    32'hFF22FF44);
        check("late_aw_wready_low", ok, 1);
        @(posedge aclk); #1;
        check("late_aw_ready_back", {s_axil_awready, s_axil_wready, s_axil_bvalid}, 3'b110);
        m_write(32'h4, 32'h11223344, 4'b0101);

        // Write response backpressure
        s_axil_bready = 1'b0;
        s_axil_awaddr = 32'h1C; s_axil_wdata = 32'h5A5A0F0F; s_axil_wstrb = 4'hF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        @(posedge aclk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        @(posedge aclk); #1;
        check("bp_w_bvalid", s_axil_bvalid, 1);
        check("bp_w_pulse",  reg_wr_pulse, 16'h0080);
        ok = 1;
        repeat (10) begin
            @(posedge aclk); #1;
            ok = ok && s_axil_bvalid && (s_axil_bresp == 2'b00) && !s_axil_awready &&
                 !s_axil_wready && (reg_wr_pulse == 16'h0);
        end
        check("bp_w_hold", ok, 1);
        s_axil_bready = 1'b1;
        @(posedge aclk); #1;
        check("bp_w_release", {s_axil_bvalid, s_axil_awready, s_axil_wready}, 3'b011);
        m_write(32'h1C, 32'h5A5A0F0F, 4'hF);
        check("bp_w_regs", regs_match(), 1);

        // Read data backpressure
        s_axil_rready = 1'b0;
        s_axil_araddr = 32'h1C; s_axil_arvalid = 1'b1;
        @(posedge aclk); #1;
        s_axil_arvalid = 1'b0;
        check("bp_r_rvalid", s_axil_rvalid, 1);
        check("bp_r_rdata",  s_axil_rdata, 32'h5A5A0F0F);
        ok = 1;
        s_axil_araddr = 32'h40;
        repeat (10) begin
            @(posedge aclk); #1;
            ok = ok && s_axil_rvalid && (s_axil_rdata == 32'h5A5A0F0F) &&
                 (s_axil_rresp == 2'b00) && !s_axil_arready;
        end
        check("bp_r_hold", ok, 1);
        s_axil_rready = 1'b1;
        @(posedge aclk); #1;
        check("bp_r_release", {s_axil_rvalid, s_axil_arready}, 2'b01);

        // Read and write to the same register resolving on one edge
        do_write(32'h14, 32'h01010101, 4'hF, 0, 0, r, p, p2, lat);
        m_write(32'h14, 32'h01010101, 4'hF);
        s_axil_bready = 1'b1; s_axil_rready = 1'b0;
        s_axil_awaddr = 32'h14; s_axil_wdata = 32'h02020202; s_axil_wstrb = 4'hF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        @(posedge aclk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        s_axil_araddr = 32'h14; s_axil_arvalid = 1'b1;
        @(posedge aclk); #1;
        s_axil_arvalid = 1'b0;
        check("same_edge_rvalid", s_axil_rvalid, 1);
        check("same_edge_rdata",  s_axil_rdata, 32'h01010101);
        check("same_edge_reg5",   reg_out[5], 32'h02020202);
        s_axil_rready = 1'b1;
        @(posedge aclk); #1;
        m_write(32'h14, 32'h02020202, 4'hF);

        // Randomized phase against the model
        for (int n = 0; n < 80; n++) begin
            for (int i = 0; i < 16; i++) reg_in[i] = $urandom;
            a = 32'($urandom_range(0, 32'h4F));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                er = m_wresp(a);
                ed = {16'h0, m_pulse(a)};
                do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), r, p, p2, lat);
                m_write(a, d, s);
                check($sformatf("rnd%0d_bresp a=%0h", n, a), r, er);
                check($sformatf("rnd%0d_pulse a=%0h", n, a), p, ed[15:0]);
                check($sformatf("rnd%0d_pulse_len", n), p2, 0);
                check($sformatf("rnd%0d_blat", n), lat, 1);
                check($sformatf("rnd%0d_regs", n), regs_match(), 1);
            end else begin
                m_read(a, ed, er);
                do_read(a, rd, r, lat);
                check($sformatf("rnd%0d_rdata a=%0h", n, a), rd, ed);
                check($sformatf("rnd%0d_rresp a=%0h", n, a), r, er);
                check($sformatf("rnd%0d_rlat", n), lat, 0);
            end
        end

        // Reset while a write response and a read response are pending
        reg_in[3] = 32'hCAFE0001;
        s_axil_bready = 1'b0; s_axil_rready = 1'b0;
        s_axil_awaddr = 32'h18; s_axil_wdata = 32'h00000077; s_axil_wstrb = 4'hF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        s_axil_araddr = 32'h08; s_axil_arvalid = 1'b1;
        @(posedge aclk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
        @(posedge aclk); #1;
        check("pre_rst_bvalid", s_axil_bvalid, 1);
        check("pre_rst_rvalid", s_axil_rvalid, 1);
        #2 aresetn = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        check("mid_rst_valids", {s_axil_bvalid, s_axil_rvalid}, 2'b00);
        check("mid_rst_readys", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
        check("mid_rst_payload", {s_axil_bresp, s_axil_rresp, s_axil_rdata}, 36'h0);
        check("mid_rst_pulse", reg_wr_pulse, 0);
        check("mid_rst_regs", regs_match(), 1);
        @(negedge aclk);
        aresetn = 1'b1;
        ok = 1;
        repeat (3) begin
            @(posedge aclk); #1;
            ok = ok && !s_axil_bvalid && !s_axil_rvalid && (reg_wr_pulse == 16'h0);
        end
        check("post_rst_no_stale", ok, 1);
        do_write(32'h18, 32'hABCD0123, 4'hF, 0, 0, r, p, p2, lat);
        m_write(32'h18, 32'hABCD0123, 4'hF);
        check("post_rst_bresp", r, 0);
        check("post_rst_pulse", p, 16'h0040);
        check("post_rst_blat",  lat, 1);
        check("post_rst_regs",  regs_match(), 1);
        do_read(32'h18, rd, r, lat);
        check("post_rst_rdata", rd, 32'hABCD0123);
        check("post_rst_rresp", r, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
